// File: rtl/uart_echo_unit.sv
// uart_echo_unit: 8N1 UART loopback. A two-flop synchronizer feeds a
// mid-bit-sampling receiver. Each correctly framed byte goes into a one-byte
// holding buffer, and a transmitter re-sends it unchanged.
// A framing error or a buffer overflow sets the sticky err flag.
//
// Receiver / transmitter states (same encoding for both FSMs):
//   state   | meaning
//   S_IDLE  | line idle; rx: waiting for a start bit, tx: waiting for the buffer
//   S_START | start bit in progress (rx: half-bit check, tx: driving 0)
//   S_DATA  | eight data bits, LSB first, one bit period each
//   S_STOP  | stop bit (rx: sample and check, tx: driving 1)
module uart_echo_unit #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic tx,
  output logic err
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] C_BIT  = CW'(DIV - 1);
  // The IDLE cycle that detects the start bit is the first cycle of the
  // half bit. START therefore needs DIV/2-1 more cycles before it samples.
  localparam logic [CW-1:0] C_HALF = CW'(DIV / 2 - 2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic r_rx_meta, r_rx_s;

  state_t         r_rx_state, w_rx_state;
  logic [CW-1:0]  r_rx_cnt,   w_rx_cnt;
  logic [2:0]     r_rx_bit,   w_rx_bit;
  logic [7:0]     r_rx_shift, w_rx_shift;
  logic           r_rx_wait,  w_rx_wait;
  logic           w_rx_done,  w_rx_ferr;

  logic [7:0]     r_buf;
  logic           r_buf_valid;
  logic           r_err;

  state_t         r_tx_state, w_tx_state;
  logic [CW-1:0]  r_tx_cnt,   w_tx_cnt;
  logic [2:0]     r_tx_bit,   w_tx_bit;
  logic [7:0]     r_tx_shift, w_tx_shift;
  logic           r_tx,       w_tx;
  logic           w_tx_load;

  // Two-flop synchronizer for the asynchronous rx pin; it resets to idle (high).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_wait  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state;
      r_rx_cnt   <= w_rx_cnt;
      r_rx_bit   <= w_rx_bit;
      r_rx_shift <= w_rx_shift;
      r_rx_wait  <= w_rx_wait;
    end
  end

  // Receiver next state: down-counter per bit, sample when it reaches zero.
  always_comb begin
    w_rx_state = r_rx_state;
    w_rx_cnt   = r_rx_cnt;
    w_rx_bit   = r_rx_bit;
    w_rx_shift = r_rx_shift;
    w_rx_wait  = r_rx_wait;
    w_rx_done  = 1'b0;
    w_rx_ferr  = 1'b0;
    case (r_rx_state)
      S_IDLE: begin
        if (r_rx_wait) begin
          // After a framing error, stay disarmed until the line returns high.
          if (r_rx_s) w_rx_wait = 1'b0;
        end else if (!r_rx_s) begin
          w_rx_state = S_START;
          w_rx_cnt   = C_HALF;
          w_rx_bit   = '0;
        end
      end
      S_START: begin
        if (r_rx_cnt == '0) begin
          if (!r_rx_s) begin
            w_rx_state = S_DATA;
            w_rx_cnt   = C_BIT;
          end else begin
            w_rx_state = S_IDLE;
          end
        end else begin
          w_rx_cnt = r_rx_cnt - CW'(1);
        end
      end
      S_DATA: begin
        if (r_rx_cnt == '0) begin
          w_rx_shift = {r_rx_s, r_rx_shift[7:1]};
          w_rx_cnt   = C_BIT;
          if (r_rx_bit == 3'd7) w_rx_state = S_STOP;
          else                  w_rx_bit   = r_rx_bit + 3'd1;
        end else begin
          w_rx_cnt = r_rx_cnt - CW'(1);
        end
      end
      S_STOP: begin
        if (r_rx_cnt == '0) begin
          w_rx_state = S_IDLE;
          if (r_rx_s) begin
            w_rx_done = 1'b1;
          end else begin
            w_rx_ferr = 1'b1;
            w_rx_wait = 1'b1;
          end
        end else begin
          w_rx_cnt = r_rx_cnt - CW'(1);
        end
      end
      default: w_rx_state = S_IDLE;
    endcase
  end

  // Holding buffer and sticky error. A write in the same cycle as a
  // transmitter load is not an overflow: the load takes the old byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf       <= '0;
      r_buf_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_rx_done && (!r_buf_valid || w_tx_load)) begin
        r_buf       <= r_rx_shift;
        r_buf_valid <= 1'b1;
      end else if (w_tx_load) begin
        r_buf_valid <= 1'b0;
      end
      if (w_rx_ferr || (w_rx_done && r_buf_valid && !w_tx_load))
        r_err <= 1'b1;
    end
  end

  // Transmitter state register; tx is registered so the pin never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_cnt   <= w_tx_cnt;
      r_tx_bit   <= w_tx_bit;
      r_tx_shift <= w_tx_shift;
      r_tx       <= w_tx;
    end
  end

  // Transmitter next state. At the end of a stop bit it can go straight to the
  // next start bit, so back-to-back frames have no idle gap.
  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_cnt   = r_tx_cnt;
    w_tx_bit   = r_tx_bit;
    w_tx_shift = r_tx_shift;
    w_tx       = r_tx;
    w_tx_load  = 1'b0;
    case (r_tx_state)
      S_IDLE: begin
        w_tx = 1'b1;
        if (r_buf_valid) begin
          w_tx_load  = 1'b1;
          w_tx_state = S_START;
          w_tx_cnt   = C_BIT;
          w_tx_shift = r_buf;
          w_tx       = 1'b0;
        end
      end
      S_START: begin
        if (r_tx_cnt == '0) begin
          w_tx_state = S_DATA;
          w_tx_cnt   = C_BIT;
          w_tx_bit   = '0;
          w_tx       = r_tx_shift[0];
        end else begin
          w_tx_cnt = r_tx_cnt - CW'(1);
        end
      end
      S_DATA: begin
        if (r_tx_cnt == '0) begin
          w_tx_cnt = C_BIT;
          if (r_tx_bit == 3'd7) begin
            w_tx_state = S_STOP;
            w_tx       = 1'b1;
          end else begin
            w_tx_bit   = r_tx_bit + 3'd1;
            w_tx_shift = {1'b0, r_tx_shift[7:1]};
            w_tx       = r_tx_shift[1];
          end
        end else begin
          w_tx_cnt = r_tx_cnt - CW'(1);
        end
      end
      S_STOP: begin
        if (r_tx_cnt == '0) begin
          if (r_buf_valid) begin
            w_tx_load  = 1'b1;
            w_tx_state = S_START;
            w_tx_cnt   = C_BIT;
            w_tx_shift = r_buf;
            w_tx       = 1'b0;
          end else begin
            w_tx_state = S_IDLE;
            w_tx       = 1'b1;
          end
        end else begin
          w_tx_cnt = r_tx_cnt - CW'(1);
        end
      end
      default: begin
        w_tx_state = S_IDLE;
        w_tx       = 1'b1;
      end
    endcase
  end

  assign tx  = r_tx;
  assign err = r_err;

endmodule

// File: tb/tb_uart_echo_unit.sv
// Testbench for uart_echo_unit. It drives serial bytes on rx, records tx on
// every falling clock edge, and decodes the record into frames. Each frame
// must match the ideal 8N1 waveform of the byte it carries, cycle by cycle.
module tb_uart_echo_unit;

  localparam int DIV = 100;
  localparam int FRAME = 10 * DIV;

  logic clk, rst, rx, tx, err;

  int n_assert = 0;
  int n_fail   = 0;

  logic       tx_hist[$];
  logic [7:0] got_data[$];
  int         got_start[$];
  int         shape_err;
  int         rx_fall_idx;

  uart_echo_unit #(.CLK_FREQ(100_000_000), .BAUD(1_000_000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One tx sample per cycle; index k holds tx after rising edge k.
  always @(negedge clk) tx_hist.push_back(tx);

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Call only just after a rising edge; returns just after a rising edge.
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_v, input int gap);
    rx_fall_idx = tx_hist.size();
    hold(1'b0, DIV);
    for (int k = 0; k < 8; k++) hold(d[k], DIV);
    hold(stop_v, DIV);
    hold(1'b1, gap);
  endtask

  // Find every frame in tx_hist[ws..we) and compare its whole 10-bit
  // waveform with the ideal frame for the byte read at mid-bit.
  task automatic decode(input int ws, input int we);
    int i;
    logic [7:0] b;
    logic expv;
    got_data.delete();
    got_start.delete();
    shape_err = 0;
    i = ws;
    while (i < we) begin
      if (tx_hist[i] === 1'b0) begin
        if (i + FRAME > tx_hist.size()) begin
          shape_err++;
          break;
        end
        for (int k = 0; k < 8; k++) b[k] = tx_hist[i + DIV/2 + (k+1)*DIV];
        for (int j = 0; j < FRAME; j++) begin
          if (j < DIV)                expv = 1'b0;
          else if (j >= 9*DIV)        expv = 1'b1;
          else                        expv = b[j/DIV - 1];
          if (tx_hist[i+j] !== expv) shape_err++;
        end
        got_data.push_back(b);
        got_start.push_back(i);
        i = i + FRAME;
      end else begin
        i++;
      end
    end
  endtask

  task automatic check_frames(input string tag, input logic [7:0] exp_q[$]);
    chk({tag, "_count"}, got_data.size(), exp_q.size());
    chk({tag, "_shape"}, shape_err, 0);
    for (int k = 0; k < exp_q.size() && k < got_data.size(); k++)
      chk($sformatf("%s_byte%0d", tag, k), int'(got_data[k]), int'(exp_q[k]));
  endtask

  initial begin
    int ws, lat, first_fall;
    logic [7:0] exp_q[$];
    logic [7:0] d;

    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_tx", tx, 1);
    chk("reset_err", err, 0);

    // Idle line
    ws = tx_hist.size();
    hold(1'b1, 1000);
    decode(ws, tx_hist.size());
    exp_q.delete();
    check_frames("idle", exp_q);

    // Single byte 0x96 with latency check
    ws = tx_hist.size();
    send_byte(8'h96, 1'b1, 1200);
    decode(ws, tx_hist.size());
    exp_q = '{8'h96};
    check_frames("single", exp_q);
    lat = (got_start.size() > 0) ? got_start[0] - rx_fall_idx : -1;
    chk("single_latency_in_952_954", int'(lat >= 952 && lat <= 954), 1);
    chk("single_err", err, 0);

    // Framing error: the byte is dropped and err stays set
    ws = tx_hist.size();
    send_byte(8'h55, 1'b0, 1200);
    decode(ws, tx_hist.size());
    exp_q.delete();
    check_frames("ferr", exp_q);
    chk("ferr_err", err, 1);
    hold(1'b1, 500);
    chk("ferr_err_sticky", err, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ferr_err_cleared", err, 0);

    // Glitch shorter than half a bit
    ws = tx_hist.size();
    hold(1'b0, 20);
    hold(1'b1, 1200);
    decode(ws, tx_hist.size());
    exp_q.delete();
    check_frames("glitch", exp_q);
    chk("glitch_err", err, 0);

    // Back-to-back frames with no idle gap
    ws = tx_hist.size();
    first_fall = ws;
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'hFF, 1'b1, 0);
    send_byte(8'hA5, 1'b1, 1200);
    decode(ws, tx_hist.size());
    exp_q = '{8'h00, 8'hFF, 8'hA5};
    check_frames("b2b", exp_q);
    if (got_start.size() == 3) begin
      chk("b2b_gap01", got_start[1] - got_start[0], FRAME);
      chk("b2b_gap12", got_start[2] - got_start[1], FRAME);
      lat = got_start[0] - first_fall;
      chk("b2b_latency_in_952_954", int'(lat >= 952 && lat <= 954), 1);
    end
    chk("b2b_err", err, 0);

    // Random bytes with random idle gaps
    ws = tx_hist.size();
    exp_q.delete();
    for (int n = 0; n < 6; n++) begin
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(d);
      send_byte(d, 1'b1, (n == 5) ? 1200 : int'($urandom_range(0, 300)));
    end
    decode(ws, tx_hist.size());
    check_frames("rand", exp_q);
    chk("rand_err", err, 0);

    // Reset during echo data bit 4 of 0xA5 (bit 4 is 0, so tx is low then)
    d = 8'hA5;
    send_byte(d, 1'b1, 0);
    while (tx_hist.size() < rx_fall_idx + 953 + 5*DIV + DIV/2) @(posedge clk);
    #1;
    chk("midrst_tx_before", tx, int'(d[4]));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_tx_after", tx, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    ws = tx_hist.size();
    hold(1'b1, 1500);
    decode(ws, tx_hist.size());
    exp_q.delete();
    check_frames("midrst_residual", exp_q);

    ws = tx_hist.size();
    send_byte(8'h3C, 1'b1, 1200);
    decode(ws, tx_hist.size());
    exp_q = '{8'h3C};
    check_frames("post_rst", exp_q);
    chk("post_rst_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
